// File: rtl/fsm_seq_pkg.sv
// fsm_seq_pkg: shared state, path, switch and LED encodings for the sequence driver
package fsm_seq_pkg;
  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_DRIVE = 3'd1;
  localparam logic [2:0] ST_CHECK = 3'd2;
  localparam logic [2:0] ST_GAP   = 3'd3;
  localparam logic [2:0] ST_DONE  = 3'd4;
  localparam logic [2:0] ST_FAIL  = 3'd5;

  typedef enum logic [2:0] {
    S_IDLE  = ST_IDLE,
    S_DRIVE = ST_DRIVE,
    S_CHECK = ST_CHECK,
    S_GAP   = ST_GAP,
    S_DONE  = ST_DONE,
    S_FAIL  = ST_FAIL
  } state_t;

  localparam logic [1:0] PATH_FULL  = 2'b00;
  localparam logic [1:0] PATH_A     = 2'b01;
  localparam logic [1:0] PATH_B     = 2'b10;
  localparam logic [1:0] PATH_ALIAS = 2'b11;

  localparam logic [2:0] SW_OFF = 3'b000;
  localparam logic [2:0] SW_C1  = 3'b001;
  localparam logic [2:0] SW_C2  = 3'b010;
  localparam logic [2:0] SW_C3  = 3'b011;
  localparam logic [2:0] SW_C4  = 3'b100;
  localparam logic [2:0] SW_C5  = 3'b101;
  localparam logic [2:0] SW_C6  = 3'b110;

  localparam logic [2:0] LED_C0 = 3'b000;
  localparam logic [2:0] LED_C1 = 3'b001;
  localparam logic [2:0] LED_C2 = 3'b010;
  localparam logic [2:0] LED_C3 = 3'b011;
  localparam logic [2:0] LED_C4 = 3'b100;
  localparam logic [2:0] LED_C7 = 3'b111;
endpackage

// File: rtl/fsm_seq_rom.sv
// fsm_seq_rom: combinational step table, (path, step) -> sw code, expected led, last flag
module fsm_seq_rom
  import fsm_seq_pkg::*;
(
  input  logic [1:0] path,
  input  logic [2:0] step,
  output logic [2:0] sw_code,
  output logic [2:0] led_exp,
  output logic       last
);
  // Table lookup; path 11 aliases the full six-step path, unused slots read as off
  always_comb begin
    sw_code = SW_OFF;
    led_exp = LED_C0;
    last    = 1'b0;
    case (path)
      PATH_A: begin
        last = step == 3'd3;
        case (step)
          3'd0: begin sw_code = SW_C4; led_exp = LED_C3; end
          3'd1: begin sw_code = SW_C4; led_exp = LED_C4; end
          3'd2: begin sw_code = SW_C5; led_exp = LED_C7; end
          3'd3: begin sw_code = SW_C6; led_exp = LED_C0; end
          default: ;
        endcase
      end
      PATH_B: begin
        last = step == 3'd3;
        case (step)
          3'd0: begin sw_code = SW_C1; led_exp = LED_C1; end
          3'd1: begin sw_code = SW_C4; led_exp = LED_C4; end
          3'd2: begin sw_code = SW_C5; led_exp = LED_C7; end
          3'd3: begin sw_code = SW_C6; led_exp = LED_C0; end
          default: ;
        endcase
      end
      default: begin
        last = step == 3'd5;
        case (step)
          3'd0: begin sw_code = SW_C1; led_exp = LED_C1; end
          3'd1: begin sw_code = SW_C2; led_exp = LED_C2; end
          3'd2: begin sw_code = SW_C3; led_exp = LED_C3; end
          3'd3: begin sw_code = SW_C4; led_exp = LED_C4; end
          3'd4: begin sw_code = SW_C5; led_exp = LED_C7; end
          3'd5: begin sw_code = SW_C6; led_exp = LED_C0; end
          default: ;
        endcase
      end
    endcase
  end
endmodule

// File: rtl/fsm_seq_driver.sv
// fsm_seq_driver: drives a switch-code sequence and checks LED feedback; FSM_SEQ_DRIVER_CHECK_EN enables led checking/timeout
module fsm_seq_driver
  import fsm_seq_pkg::*;
#(
  parameter int HOLD_CYCLES    = 4,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       start,
  input  logic [1:0] path_sel,
  input  logic [2:0] led_in,
  output logic [2:0] sw,
  output logic       busy,
  output logic       done,
  output logic       error,
  output logic [2:0] step
);
  state_t     state_q, state_d;
  logic [1:0] path_q, path_d;
  logic [2:0] step_q, step_d;
  logic [2:0] sw_q, sw_d;
  logic [7:0] cnt_q, cnt_d;
  logic       busy_q, busy_d, done_q, done_d, error_q, error_d;
  logic [2:0] cur_sw_unused, cur_led, nxt_sw, nxt_led_unused;
  logic       cur_last, nxt_last_unused, match, timeout;

  // Current entry feeds the CHECK comparison; next entry lets sw be registered in step with the state
  fsm_seq_rom u_rom_cur (.path(path_q), .step(step_q), .sw_code(cur_sw_unused), .led_exp(cur_led), .last(cur_last));
  fsm_seq_rom u_rom_nxt (.path(path_d), .step(step_d), .sw_code(nxt_sw), .led_exp(nxt_led_unused), .last(nxt_last_unused));

  assign timeout = cnt_q == 8'(TIMEOUT_CYCLES - 1);
`ifdef FSM_SEQ_DRIVER_CHECK_EN
  assign match = led_in == cur_led;
  assign error = error_q;
`else
  logic unused_chk;
  assign match      = 1'b1;
  assign unused_chk = ^{led_in, cur_led, timeout, error_q};
  assign error      = 1'b0;
`endif
  assign sw   = sw_q;
  assign busy = busy_q;
  assign done = done_q;
  assign step = step_q;

  // Next state, step/path bookkeeping and per-state counter that restarts on every state entry
  always_comb begin
    state_d = state_q;
    path_d  = path_q;
    step_d  = step_q;
    case (state_q)
      S_IDLE: if (start) begin
        state_d = S_DRIVE;
        path_d  = path_sel;
        step_d  = 3'd0;
      end
      S_DRIVE: if (cnt_q == 8'(HOLD_CYCLES - 1)) state_d = S_CHECK;
      S_CHECK: state_d = match ? (cur_last ? S_DONE : S_GAP) : (timeout ? S_FAIL : S_CHECK);
      S_GAP: begin
        state_d = S_DRIVE;
        step_d  = step_q + 3'd1;
      end
      default: state_d = S_IDLE;
    endcase
    cnt_d = (state_d != state_q || state_q == S_IDLE) ? 8'd0 : cnt_q + 8'd1;
  end

  // Registered outputs decoded from the upcoming state
  always_comb begin
    sw_d    = (state_d == S_DRIVE || state_d == S_CHECK) ? nxt_sw : SW_OFF;
    busy_d  = state_d != S_IDLE;
    done_d  = state_d == S_DONE;
    error_d = (state_q == S_IDLE && start) ? 1'b0 : (state_d == S_FAIL) ? 1'b1 : error_q;
  end

  // State and output flops, cleared immediately by reset
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      path_q  <= PATH_FULL;
      step_q  <= 3'd0;
      cnt_q   <= 8'd0;
      sw_q    <= SW_OFF;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      error_q <= 1'b0;
    end else begin
      state_q <= state_d;
      path_q  <= path_d;
      step_q  <= step_d;
      cnt_q   <= cnt_d;
      sw_q    <= sw_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      error_q <= error_d;
    end
  end
endmodule

// File: tb/tb_fsm_seq_driver.sv
// tb_fsm_seq_driver: directed bench for fsm_seq_driver; honours FSM_SEQ_DRIVER_CHECK_EN
module tb_fsm_seq_driver;
  localparam int H = 4;
  localparam int T = 16;
`ifdef FSM_SEQ_DRIVER_CHECK_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       start = 1'b0;
  logic [1:0] path_sel = 2'b00;
  logic [2:0] led_in = 3'b000;
  logic [2:0] sw, step;
  logic       busy, done, error;
  int         n_tests = 0;
  int         n_fail = 0;
  logic [2:0] tsw [3][6];
  logic [2:0] tled[3][6];

  fsm_seq_driver #(.HOLD_CYCLES(H), .TIMEOUT_CYCLES(T)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .path_sel(path_sel), .led_in(led_in),
    .sw(sw), .busy(busy), .done(done), .error(error), .step(step)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Builds the expected per-cycle trace from the tables, then runs and compares it cycle by cycle
  task automatic run_seq(input logic [1:0] p, input int late_step, input int late, input bit glitch, input bit led_zero);
    int n = (p == 2'b01 || p == 2'b10) ? 4 : 6;
    int pi = (p == 2'b11) ? 0 : int'(p);
    logic [2:0] esw[$];
    logic [2:0] eled[$];
    logic [2:0] estp[$];
    for (int s = 0; s < n; s++) begin
      int ext = (CHK && s == late_step) ? late : 0;
      for (int h = 0; h < H; h++) begin
        esw.push_back(tsw[pi][s]);
        eled.push_back(led_zero ? 3'b000 : (ext > 0 ? tled[pi][s] ^ 3'b111 : tled[pi][s]));
        estp.push_back(3'(s));
      end
      for (int e = 0; e <= ext; e++) begin
        esw.push_back(tsw[pi][s]);
        eled.push_back(led_zero ? 3'b000 : (e < ext ? tled[pi][s] ^ 3'b111 : tled[pi][s]));
        estp.push_back(3'(s));
      end
      esw.push_back(3'b000);
      eled.push_back(3'b000);
      estp.push_back(3'(s));
    end
    start = 1'b1;
    path_sel = p;
    tick();
    start = 1'b0;
    path_sel = ~p;
    for (int i = 0; i < esw.size(); i++) begin
      led_in = eled[i];
      start = glitch && (i == 2 || i == 3 || i == 13);
      path_sel = glitch ? 2'b01 : ~p;
      chk("sw", {29'd0, sw}, {29'd0, esw[i]});
      chk("step", {29'd0, step}, {29'd0, estp[i]});
      chk("done", {31'd0, done}, {31'd0, i == esw.size() - 1});
      chk("busy", {31'd0, busy}, 32'd1);
      chk("error", {31'd0, error}, 32'd0);
      tick();
    end
    start = 1'b0;
    chk("idle_busy", {31'd0, busy}, 32'd0);
    chk("idle_done", {31'd0, done}, 32'd0);
    chk("idle_sw", {29'd0, sw}, 32'd0);
    tick();
    chk("idle_busy2", {31'd0, busy}, 32'd0);
  endtask

  initial begin
    tsw[0] = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6};
    tled[0] = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd7, 3'd0};
    tsw[1] = '{3'd4, 3'd4, 3'd5, 3'd6, 3'd0, 3'd0};
    tled[1] = '{3'd3, 3'd4, 3'd7, 3'd0, 3'd0, 3'd0};
    tsw[2] = '{3'd1, 3'd4, 3'd5, 3'd6, 3'd0, 3'd0};
    tled[2] = '{3'd1, 3'd4, 3'd7, 3'd0, 3'd0, 3'd0};
    #2;
    chk("rst_sw", {29'd0, sw}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_error", {31'd0, error}, 32'd0);
    chk("rst_step", {29'd0, step}, 32'd0);
    tick();
    reset_n = 1'b1;
    tick();
    tick();
    chk("idle_nostart", {31'd0, busy}, 32'd0);
    run_seq(2'b00, -1, 0, 1'b0, 1'b0);
    run_seq(2'b01, -1, 0, 1'b0, 1'b0);
    run_seq(2'b11, -1, 0, 1'b0, 1'b0);
    run_seq(2'b00, -1, 0, 1'b1, 1'b0);
    if (CHK) begin
      start = 1'b1;
      path_sel = 2'b01;
      tick();
      start = 1'b0;
      led_in = 3'b000;
      for (int i = 0; i < H + T; i++) begin
        chk("to_sw", {29'd0, sw}, 32'd4);
        chk("to_busy", {31'd0, busy}, 32'd1);
        chk("to_error", {31'd0, error}, 32'd0);
        tick();
      end
      chk("fail_sw", {29'd0, sw}, 32'd0);
      chk("fail_error", {31'd0, error}, 32'd1);
      chk("fail_busy", {31'd0, busy}, 32'd1);
      chk("fail_done", {31'd0, done}, 32'd0);
      tick();
      chk("post_busy", {31'd0, busy}, 32'd0);
      chk("post_error", {31'd0, error}, 32'd1);
      chk("post_sw", {29'd0, sw}, 32'd0);
      tick();
      tick();
      chk("sticky_error", {31'd0, error}, 32'd1);
    end else begin
      run_seq(2'b00, -1, 0, 1'b0, 1'b1);
    end
    run_seq(2'b10, 2, 3, 1'b0, 1'b0);
    start = 1'b1;
    path_sel = 2'b00;
    tick();
    start = 1'b0;
    for (int c = 1; c < 20; c++) begin
      led_in = tled[0][(c - 1) / (H + 2)];
      tick();
    end
    chk("mid_sw", {29'd0, sw}, 32'd4);
    chk("mid_step", {29'd0, step}, 32'd3);
    reset_n = 1'b0;
    #1;
    chk("ar_sw", {29'd0, sw}, 32'd0);
    chk("ar_busy", {31'd0, busy}, 32'd0);
    chk("ar_step", {29'd0, step}, 32'd0);
    chk("ar_done", {31'd0, done}, 32'd0);
    #1;
    reset_n = 1'b1;
    for (int c = 0; c < 10; c++) begin
      tick();
      chk("quiet_busy", {31'd0, busy}, 32'd0);
      chk("quiet_sw", {29'd0, sw}, 32'd0);
    end
    run_seq(2'b00, -1, 0, 1'b0, 1'b0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/fsm_seq_driver.md
FSM_SEQ_DRIVER -- requirements
Module: fsm_seq_driver

Interface
REQ-001 SHALL have parameter HOLD_CYCLES, default 4, cycles each sw code is held (range 1..255).
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 16, max CHECK cycles awaiting led match (range 1..255).
REQ-003 SHALL have port clk  input  1  single clock, all flops on rising edge.
REQ-004 SHALL have port reset_n  input  1  asynchronous active-low reset.
REQ-005 SHALL have port start  input  1  request to run one sequence; sampled only in IDLE.
REQ-006 SHALL have port path_sel  input  2  sequence select, sampled with start.
REQ-007 SHALL have port led_in  input  3  state code fed back from the switch-sequence FSM.
REQ-008 SHALL have port sw  output  3  switch code driven to the switch-sequence FSM.
REQ-009 SHALL have port busy  output  1  high in every state except IDLE.
REQ-010 SHALL have port done  output  1  one-cycle pulse on successful completion.
REQ-011 SHALL have port error  output  1  sticky failure flag.
REQ-012 SHALL have port step  output  3  index of the step currently driven (0-based).

Function
REQ-013 SHALL implement states IDLE, DRIVE, CHECK, GAP, DONE, FAIL.
REQ-014 SHALL encode paths as (sw code/expected led per step): 00 = 001/001, 010/010, 011/011, 100/100, 101/111, 110/000 (6 steps); 01 = 100/011, 100/100, 101/111, 110/000 (4 steps); 10 = 001/001, 100/100, 101/111, 110/000 (4 steps); 11 SHALL behave as 00.
REQ-015 SHALL in IDLE drive sw=000; start=1 latches path_sel, clears error, sets step=0, moves to DRIVE.
REQ-016 SHALL in DRIVE drive the current step's sw code for exactly HOLD_CYCLES cycles, then enter CHECK.
REQ-017 SHALL in CHECK keep sw at the current code; led_in equal to expected -> GAP (or DONE if last step); otherwise wait, and after TIMEOUT_CYCLES CHECK cycles without match -> FAIL.
REQ-018 SHALL in GAP drive sw=000 for one cycle, increment step, return to DRIVE.
REQ-019 SHALL in DONE drive sw=000, assert done for one cycle, return to IDLE.
REQ-020 SHALL in FAIL drive sw=000, set error, return to IDLE next cycle; error holds until the next accepted start.
REQ-021 SHALL ignore start in every state except IDLE; path_sel changes after acceptance SHALL have no effect.
REQ-022 SHALL with immediate matches complete in N*(HOLD_CYCLES+2) cycles: done high in cycle N*(HOLD_CYCLES+2) after the start-sampling edge, N = step count.
REQ-023 SHALL use saturating-free counters sized 8 bits, reloaded to 0 on every state entry.

Reset
REQ-024 SHALL on reset_n low immediately force IDLE, sw=000, busy=0, done=0, error=0, step=0, counters=0, regardless of state.
REQ-025 SHALL after reset_n deasserted mid-sequence require a new start; no step resumes.

Configuration
REQ-026 SHALL honour macro FSM_SEQ_DRIVER_CHECK_EN: defined -> REQ-017 as written; undefined -> led_in ignored, CHECK lasts exactly one cycle and always passes, FAIL unreachable, error tied 0; latency of REQ-022 unchanged.

Structure
REQ-027 SHALL place state encodings, path encodings, sw codes and expected led codes as localparams in shared package fsm_seq_pkg.
REQ-028 SHALL implement the step table as combinational sub-module fsm_seq_rom: (path, step) -> sw code, expected led, last flag.

Verification
REQ-029 SHALL cover: path 00, led_in mirrors expected immediately, HOLD=4 -> sw 001,000,010,000,...,110, done high in cycle 36, error=0.
REQ-030 SHALL cover: path 01, led_in stuck at 000, TIMEOUT=16 (CHECK_EN) -> FAIL after 16 CHECK cycles at step 0, error=1, sw=000, busy=0 next cycle.
REQ-031 SHALL cover: path 10, led_in matches 3 cycles late on step 2 -> done in cycle 4*6+3=27, error=0.
REQ-032 SHALL cover: start pulsed while busy with path_sel=01 during a path-00 run -> ignored, all 6 steps driven.
REQ-033 SHALL cover: reset_n low during step 3 DRIVE -> sw=000, busy=0, step=0 same cycle; no activity until next start.
REQ-034 SHALL cover: macro undefined, led_in=000 constant, path 00 -> done in cycle 36, error=0.
